// File: rtl/ldm_stm_pkg.sv
// Shared types and helpers for the LDM/STM sequencer.
package ldm_stm_pkg;

  typedef enum logic [1:0] {IDLE, XFER, WBACK, DONE} seq_state_t;

  localparam logic [3:0] PC_REG = 4'd15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest 1 in vec, none when vec is zero.
module lsb_prio_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        none
);

  always_comb begin
    idx  = '0;
    none = (vec == 16'd0);
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: walks the register list one transfer per memory ack,
// then optionally writes the updated base back to rn.
module ldm_stm_seq
  import ldm_stm_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        pre,
  input  logic        up,
  input  logic        wback,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic [15:0] reglist,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        pc_load
);

  localparam logic [31:0] STEP_W = 32'(STEP);

  seq_state_t  state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] fbase_q, fbase_d;
  logic        is_load_q, is_load_d;
  logic        do_wb_q, do_wb_d;
  logic [3:0]  rn_q, rn_d;

  logic [3:0]  cur;
  logic        cur_none;
  logic [31:0] span;
  logic        last;
  logic        xfer_ack;

  lsb_prio_enc u_enc (
    .vec  (mask_q),
    .idx  (cur),
    .none (cur_none)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      addr_q    <= '0;
      fbase_q   <= '0;
      is_load_q <= 1'b0;
      do_wb_q   <= 1'b0;
      rn_q      <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      fbase_q   <= fbase_d;
      is_load_q <= is_load_d;
      do_wb_q   <= do_wb_d;
      rn_q      <= rn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    fbase_d   = fbase_q;
    is_load_d = is_load_q;
    do_wb_d   = do_wb_q;
    rn_d      = rn_q;

    span     = STEP_W * {27'b0, popcount16(reglist)};
    xfer_ack = (state_q == XFER) && mem_ack && !cur_none;
    // Only one bit left in the mask means this ack finishes the list.
    last     = ((mask_q & (mask_q - 16'd1)) == 16'd0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_load_d = is_load;
          rn_d      = rn;
          mask_d    = reglist;
          // A loaded base register takes priority over the written-back base.
          do_wb_d   = wback && !(is_load && reglist[rn]);
          fbase_d   = up ? base + span : base - span;
          if (up) addr_d = pre ? base + STEP_W : base;
          else    addr_d = pre ? base - span : base - span + STEP_W;
          if (reglist != 16'd0) state_d = XFER;
          else if (wback)       state_d = WBACK;
          else                  state_d = DONE;
        end
      end
      XFER: begin
        if (xfer_ack) begin
          mask_d = mask_q & (mask_q - 16'd1);
          addr_d = addr_q + STEP_W;
          if (last) state_d = do_wb_q ? WBACK : DONE;
        end
      end
      WBACK:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    mem_req   = (state_q == XFER);
    mem_we    = mem_req && !is_load_q;
    mem_addr  = addr_q;
    mem_wdata = rf_rd;
    rf_ra     = cur;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    pc_load   = 1'b0;
    if (state_q == XFER) begin
      rf_wa = cur;
      if (xfer_ack && is_load_q) begin
        rf_wd   = mem_rdata;
        rf_we   = (cur != PC_REG);
        pc_load = (cur == PC_REG);
      end
    end else if (state_q == WBACK) begin
      rf_we = 1'b1;
      rf_wa = rn_q;
      rf_wd = fbase_q;
    end
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Randomized bench for ldm_stm_seq against a transfer-list reference model.
module tb_ldm_stm_seq;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        pre = 1'b0;
  logic        up = 1'b0;
  logic        wback = 1'b0;
  logic [3:0]  rn = '0;
  logic [31:0] base = '0;
  logic [15:0] reglist = '0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd = '0;
  logic        rf_we, pc_load;
  logic [31:0] rf_wd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ldm_stm_seq #(.STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .pre(pre),
    .up(up), .wback(wback), .rn(rn), .base(base), .reglist(reglist),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_load(pc_load)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_pc_load"}, pc_load, 0);
    check({tag, "_rf_ra"}, rf_ra, 0);
    check({tag, "_rf_wa"}, rf_wa, 0);
    check({tag, "_rf_wd"}, rf_wd, 0);
  endtask

  // Inputs other than ack/data are scrambled mid-sequence; the DUT must ignore them.
  task automatic scramble_inputs();
    start   = 1'($urandom_range(0, 1));
    is_load = 1'($urandom_range(0, 1));
    pre     = 1'($urandom_range(0, 1));
    up      = 1'($urandom_range(0, 1));
    wback   = 1'($urandom_range(0, 1));
    rn      = 4'($urandom);
    base    = $urandom;
    reglist = 16'($urandom);
  endtask

  // ack_mode: 0 tied high, 1 random, 2 every third cycle. abort_at>0 resets after that many acks.
  task automatic run_op(input bit ld, input bit p, input bit u, input bit wb,
                        input logic [3:0] rnum, input logic [31:0] b,
                        input logic [15:0] rl, input int ack_mode,
                        input int abort_at, output int done_cycle);
    int regs[$];
    int n;
    int k;
    int acks;
    bit finished;
    bit wb_pend;
    bit exp_we;
    bit exp_pc;
    logic [31:0] fbase;
    logic [31:0] low_addr;

    for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
    n = regs.size();
    fbase = u ? b + 32'(STEP * n) : b - 32'(STEP * n);
    // Registers occupy n consecutive words; the block sits above or below base.
    if (u) low_addr = p ? b + STEP : b;
    else   low_addr = p ? fbase : fbase + STEP;
    wb_pend = wb && !(ld && rl[rnum]);
    k = 0;
    acks = 0;
    finished = 0;
    done_cycle = -1;

    @(posedge clk); #1;
    start = 1; is_load = ld; pre = p; up = u; wback = wb; rn = rnum; base = b; reglist = rl;
    mem_ack = 0;
    @(negedge clk);
    check("pre_start_busy", busy, 0);
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      scramble_inputs();
      mem_rdata = $urandom;
      rf_rd = $urandom;
      if (ack_mode == 0)      mem_ack = 1;
      else if (ack_mode == 1) mem_ack = 1'($urandom_range(0, 1));
      else                    mem_ack = (cyc % 3 == 2);
      @(negedge clk);
      if (k < n) begin
        check("mem_req", mem_req, 1);
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("mem_addr", mem_addr, low_addr + 32'(STEP * k));
        check("mem_we", mem_we, !ld);
        check("rf_ra", rf_ra, 32'(regs[k]));
        if (!ld) check("mem_wdata", mem_wdata, rf_rd);
        if (mem_ack) begin
          exp_we = ld && regs[k] != 15;
          exp_pc = ld && regs[k] == 15;
          check("rf_we", rf_we, exp_we);
          check("pc_load", pc_load, exp_pc);
          if (ld) check("rf_wd", rf_wd, mem_rdata);
          if (exp_we) check("rf_wa", rf_wa, 32'(regs[k]));
          k++;
          acks++;
        end else begin
          check("rf_we_wait", rf_we, 0);
          check("pc_load_wait", pc_load, 0);
        end
        if (abort_at > 0 && acks == abort_at) begin
          @(posedge clk); #1;
          reset = 1; mem_ack = 0; start = 0;
          @(negedge clk);
          check_all_zero("abort");
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("abort_done", done, 0);
          end
          @(posedge clk); #1;
          reset = 0;
          return;
        end
      end else if (wb_pend) begin
        check("wb_mem_req", mem_req, 0);
        check("wb_done", done, 0);
        check("wb_rf_we", rf_we, 1);
        check("wb_rf_wa", rf_wa, rnum);
        check("wb_rf_wd", rf_wd, fbase);
        wb_pend = 0;
      end else begin
        check("done", done, 1);
        check("done_busy", busy, 1);
        check("done_mem_req", mem_req, 0);
        check("done_rf_we", rf_we, 0);
        finished = 1;
        done_cycle = cyc + 1;
      end
      @(posedge clk); #1;
    end
    if (!finished) check("timeout", 0, 1);

    // Back in IDLE: a stray ack must not produce any activity.
    start = 0;
    mem_ack = 1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_rf_we", rf_we, 0);
    @(posedge clk); #1;
    mem_ack = 0;
  endtask

  initial begin
    int dc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 0;

    // STM IA, two registers, ack tied high: DONE in cycle 3.
    run_op(0, 0, 1, 0, 4'd0, 32'h1000, 16'h000A, 0, 0, dc);
    check("stm_ia_done_cycle", dc, 3);
    // LDM DB with writeback of R13.
    run_op(1, 1, 0, 1, 4'd13, 32'h2000, 16'h0007, 0, 0, dc);
    check("ldm_db_done_cycle", dc, 5);
    // LDM with R15 and base in the list: no WBACK.
    run_op(1, 0, 1, 1, 4'd2, 32'h3000, 16'h8004, 0, 0, dc);
    check("ldm_pc_done_cycle", dc, 3);
    // Empty list with writeback.
    run_op(0, 0, 1, 1, 4'd5, 32'h40, 16'h0000, 0, 0, dc);
    check("empty_done_cycle", dc, 2);
    // Empty list without writeback.
    run_op(1, 1, 0, 0, 4'd5, 32'h40, 16'h0000, 0, 0, dc);
    check("empty_nowb_done_cycle", dc, 1);
    // Wait states, reset after the 4th ack, then a normal sequence.
    run_op(1, 0, 1, 1, 4'd9, 32'h5000, 16'h00FF, 2, 4, dc);
    run_op(0, 1, 1, 1, 4'd9, 32'h5000, 16'h00FF, 2, 0, dc);
    // Address wrap at both ends of the 32-bit space.
    run_op(0, 0, 1, 1, 4'd1, 32'hFFFF_FFF8, 16'h0F00, 1, 0, dc);
    run_op(1, 1, 0, 1, 4'd3, 32'h0000_0008, 16'hFFFF, 1, 0, dc);

    for (int t = 0; t < 40; t++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom), $urandom,
             ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom),
             int'($urandom_range(0, 2)), 0, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
